gamepad_evt: RTL and testbench
==============================

Name: gamepad_evt

Overview:
- Downstream consumer of the gamepad controller's polled button word (gp_value, 48 bits for 2 pads × 2 data lines).
- Converts successive scan snapshots into a stream of per-button press/release events, buffered in a small FIFO.
- Software and peripherals can read key changes instead of polling the whole word.
- Sits between the gamepad controller and the bus/register front-end.

Parameters:
- N_BITS, 48: width of gp_value; one bit per button.
- IDX_W, 6: event index width, ceil(log2(N_BITS)).
- FIFO_DEPTH, 16: event FIFO depth; power of 2, ≥ 2.
- ACTIVE_LOW, 0: 1 means a gp_value bit of 0 is "pressed".

Ports:
- clk  in  1  system clock; the block uses one clock.
- rst_n  in  1  reset, asynchronous, active-low.
- gp_value  in  N_BITS  latest button word from the gamepad controller.
- gp_stb  in  1  one-cycle pulse when gp_value holds a complete new scan.
- evt_data  out  IDX_W+1  {pressed, button index}.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pop, valid/ready handshake.
- evt_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky: scan changes were merged while events were pending.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async assert, sync release):
  - state=INIT; cur=0, prev=0; FIFO empty; evt_valid=0; evt_data=0; evt_level=0; ovf=0.
- Normalisation:
  - btn = ACTIVE_LOW ? ~gp_value : gp_value.
  - cur is loaded with btn on every gp_stb, in any state except as noted for INIT.
- pending = cur ^ prev (combinational).
- Transfer/pop:
  - Pop happens when evt_valid && evt_ready.
  - evt_data is the FIFO head, registered (first-word fall-through).
  - Latency: a pushed event appears on evt_data/evt_valid the cycle after the push.
- INIT:
  - On the first gp_stb after reset, load cur=btn and prev=btn, then go to IDLE.
  - No events are generated, so there are no spurious power-up events.
- IDLE:
  - If pending != 0, go to SCAN. Otherwise stay.
- SCAN:
  - Each cycle, i = lowest set bit of pending.
  - If the FIFO is not full, or a pop occurs in the same cycle:
    - push {cur[i], i};
    - set prev[i] <= cur[i].
  - Otherwise stall; nothing changes.
  - When pending becomes 0, go to IDLE.
  - Throughput: 1 event/cycle.
- gp_stb while pending != 0 (in SCAN, or in IDLE the cycle pending is nonzero):
  - cur is updated anyway; set ovf=1.
  - Scanning continues against the new cur. A press+release of the same bit during the stall collapses to no event.
  - Ordering between bits is lowest index first, always.
- Simultaneous push and pop with FIFO full: allowed; level unchanged.
- Simultaneous gp_stb and push of bit i in the same cycle: push uses the old cur[i], and prev[i] takes the old cur[i]. The new cur is compared from the next cycle.
- ovf_clr and a set condition in the same cycle: set wins.
- FIFO pointers are IDX-free, wrap at FIFO_DEPTH, with an extra MSB for full/empty.
- FIFO full: no push; scanning stalls, no loss. FIFO empty: evt_valid=0; evt_ready is ignored.
- Reset mid-scan: everything returns to the reset values above; the next gp_stb re-initialises prev silently.

Decomposition:
- Shared package gamepad_pkg:
  - N_BITS default;
  - event field positions (EVT_PRESSED_BIT = IDX_W, index field [IDX_W-1:0]);
  - state encoding (INIT=0, IDLE=1, SCAN=2).
- One sub-module: gp_evt_fifo.
  - Synchronous FIFO, first-word fall-through, same clk/rst_n.
  - Ports: push, din, full, pop, dout, valid, level.
- Lowest-set-bit finder stays inline as a function.

Test Plan:
- Reset, then first gp_stb with gp_value=48'h0000_0000_0005 -> no events, state IDLE, evt_level=0.
- Then gp_stb with 48'h0000_0000_0006, evt_ready=1 -> two events in order: {0,0} (bit0 released), then {1,1} (bit1 pressed). ovf=0.
- evt_ready=0, prior word 0, gp_stb with all 48 bits set -> FIFO fills to 16 with indices 0..15 and scanning stalls. Raising evt_ready then drains indices 0..47 in order with no gaps, ovf=0.
- While stalled (evt_ready=0) with bit20 pending, gp_stb reverts bit20 -> bit20 never emitted, ovf=1. ovf_clr pulse -> ovf=0.
- ACTIVE_LOW=1: gp_value bit5 goes 1->0 -> single event {1,5}.
- rst_n asserted mid-scan with level=7 -> evt_valid=0 and level=0 immediately (async). After release, the next gp_stb produces no event.

Source files
------------

// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad event block: default sizes, event field
// layout and the scanner state encoding.
package gamepad_pkg;

  localparam int N_BITS_DEF     = 48;
  localparam int IDX_W_DEF      = 6;
  localparam int FIFO_DEPTH_DEF = 16;

  // Event word layout: {pressed, button index}.
  localparam int EVT_PRESSED_BIT = IDX_W_DEF;
  localparam int EVT_IDX_LSB     = 0;
  localparam int EVT_IDX_MSB     = IDX_W_DEF - 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

endpackage

// File: rtl/gp_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for button events; the head word
// is presented on dout the cycle after it is pushed.
module gp_evt_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_q - rd_q;
  assign valid   = (wr_q != rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem_q[rd_q[AW-1:0]] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; contents are only observable through dout,
  // which is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gamepad_evt.sv
// Turns successive gamepad scan words into per-button press/release events,
// lowest button index first, queued in a small FIFO for the bus front-end.
module gamepad_evt
  import gamepad_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_BITS-1:0]             gp_value,
  input  logic                          gp_stb,
  output logic [IDX_W:0]                evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_BITS-1:0] v);
    lowest_set = '0;
    for (int k = N_BITS - 1; k >= 0; k--) begin
      if (v[k]) lowest_set = k[IDX_W-1:0];
    end
  endfunction

  state_e             state_q;
  logic [N_BITS-1:0]  cur_q;
  logic [N_BITS-1:0]  prev_q;
  logic               ovf_q;

  logic [N_BITS-1:0]  btn;
  logic [N_BITS-1:0]  pending;
  logic               any_pend;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W:0]     push_data;
  logic               fifo_full;
  logic               fifo_pop;
  logic               push;
  logic               ovf_set;

  assign btn       = ACTIVE_LOW ? ~gp_value : gp_value;
  assign pending   = cur_q ^ prev_q;
  assign any_pend  = |pending;
  assign scan_idx  = lowest_set(pending);
  assign push_data = {cur_q[scan_idx], scan_idx};
  assign fifo_pop  = evt_valid && evt_ready;
  assign push      = (state_q == ST_SCAN) && any_pend && (!fifo_full || fifo_pop);
  // A new scan arriving while changes are still pending merges into them.
  assign ovf_set   = gp_stb && (state_q != ST_INIT) && any_pend;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cur_q   <= '0;
      prev_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // First scan after reset becomes the baseline, so no power-up events.
          if (gp_stb) begin
            cur_q   <= btn;
            prev_q  <= btn;
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (gp_stb)   cur_q   <= btn;
          if (any_pend) state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (gp_stb)    cur_q            <= btn;
          if (push)      prev_q[scan_idx] <= cur_q[scan_idx];
          if (!any_pend) state_q          <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase

      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  gp_evt_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_data),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (evt_data),
    .valid (evt_valid),
    .level (evt_level)
  );

endmodule

// File: tb/tb_gamepad_evt.sv
// Self-checking bench for gamepad_evt: vector table, hand-written corner
// sequences and randomized scans against an event-list reference model.
module tb_gamepad_evt;

  localparam logic [47:0] ALL_ONES = {48{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n;

  logic [47:0] gp_value;
  logic        gp_stb;
  logic [6:0]  evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_level;
  logic        ovf;
  logic        ovf_clr;

  logic [47:0] gp_value_l;
  logic        gp_stb_l;
  logic [6:0]  evt_data_l;
  logic        evt_valid_l;
  logic        evt_ready_l;
  logic [4:0]  evt_level_l;
  logic        ovf_l;
  logic        ovf_clr_l;

  int checks   = 0;
  int failures = 0;

  logic [6:0]  exp_q[$];
  logic [6:0]  got_q[$];
  logic [47:0] model_word;

  typedef struct {
    logic [47:0] word;
    int          n_evt;
    logic [6:0]  first_evt;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  gamepad_evt #(.ACTIVE_LOW(1'b0)) dut_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .gp_value  (gp_value),
    .gp_stb    (gp_stb),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_level (evt_level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  gamepad_evt #(.ACTIVE_LOW(1'b1)) dut_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .gp_value  (gp_value_l),
    .gp_stb    (gp_stb_l),
    .evt_data  (evt_data_l),
    .evt_valid (evt_valid_l),
    .evt_ready (evt_ready_l),
    .evt_level (evt_level_l),
    .ovf       (ovf_l),
    .ovf_clr   (ovf_clr_l)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [47:0] v);
    gp_value = v;
    gp_stb   = 1'b1;
    tick();
    gp_stb   = 1'b0;
  endtask

  // Reference: every bit that differs between two settled scans yields one
  // event carrying its new level, in ascending index order.
  task automatic model_events(input logic [47:0] old_w, input logic [47:0] new_w);
    for (int i = 0; i < 48; i++) begin
      if (old_w[i] != new_w[i]) exp_q.push_back({new_w[i], 6'(i)});
    end
  endtask

  task automatic collect(input int cycles, input bit rand_ready);
    got_q.delete();
    for (int c = 0; c < cycles; c++) begin
      evt_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (evt_valid && evt_ready) got_q.push_back(evt_data);
      tick();
    end
    evt_ready = 1'b0;
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_evt%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    check({name, "_drained"}, 64'(evt_level), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int found;
    logic [47:0] nw;

    vecs[0] = '{48'h0000_0000_0006,  2, 7'h00};
    vecs[1] = '{48'h0000_0000_0006,  0, 7'h00};
    vecs[2] = '{48'h0000_0000_0000,  2, 7'h01};
    vecs[3] = '{48'h8000_0000_0000,  1, 7'h6F};
    vecs[4] = '{48'h8000_0000_0001,  1, 7'h40};
    vecs[5] = '{48'hFFFF_0000_0000, 16, 7'h00};

    rst_n = 1'b0;
    gp_value = '0; gp_stb = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    gp_value_l = ALL_ONES; gp_stb_l = 1'b0; evt_ready_l = 1'b0; ovf_clr_l = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_level", 64'(evt_level), 64'd0);
    check("rst_data",  64'(evt_data),  64'd0);
    check("rst_ovf",   64'(ovf),       64'd0);
    rst_n = 1'b1;
    tick();

    // First scan after reset only sets the baseline.
    strobe(48'h0000_0000_0005);
    repeat (10) tick();
    check("init_level", 64'(evt_level), 64'd0);
    check("init_valid", 64'(evt_valid), 64'd0);
    model_word = 48'h0000_0000_0005;

    // Active-low instance: bit5 going 1->0 is a press.
    gp_stb_l = 1'b1; tick(); gp_stb_l = 1'b0;
    repeat (5) tick();
    check("al_init_level", 64'(evt_level_l), 64'd0);
    gp_value_l = ALL_ONES & ~(48'd1 << 5);
    gp_stb_l = 1'b1; tick(); gp_stb_l = 1'b0;
    got_q.delete();
    evt_ready_l = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (evt_valid_l) got_q.push_back(evt_data_l);
      tick();
    end
    evt_ready_l = 1'b0;
    check("al_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("al_evt", 64'(got_q[0]), 64'h45);
    check("al_ovf", 64'(ovf_l), 64'd0);

    for (int v = 0; v < 6; v++) begin
      strobe(vecs[v].word);
      model_events(model_word, vecs[v].word);
      collect(80, 1'b0);
      check($sformatf("vec%0d_n", v), 64'(got_q.size()), 64'(vecs[v].n_evt));
      if (vecs[v].n_evt > 0 && got_q.size() > 0)
        check($sformatf("vec%0d_first", v), 64'(got_q[0]), 64'(vecs[v].first_evt));
      compare_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d_ovf", v), 64'(ovf), 64'd0);
      model_word = vecs[v].word;
    end

    // Clear to zero, then press everything with no consumer: FIFO fills and stalls.
    strobe('0);
    model_events(model_word, '0);
    collect(120, 1'b0);
    compare_stream("clear");
    model_word = '0;

    evt_ready = 1'b0;
    strobe(ALL_ONES);
    repeat (100) tick();
    check("full_level", 64'(evt_level), 64'd16);
    check("full_valid", 64'(evt_valid), 64'd1);
    check("full_head",  64'(evt_data),  64'h40);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    @(negedge clk);
    check("full_pushpop_level", 64'(evt_level), 64'd16);
    check("full_pushpop_head",  64'(evt_data),  64'h41);
    tick();
    model_events(model_word, ALL_ONES);
    void'(exp_q.pop_front());
    collect(120, 1'b0);
    compare_stream("fill");
    check("fill_ovf", 64'(ovf), 64'd0);
    model_word = ALL_ONES;

    // Release all while stalled, then revert bit20 before it is scanned.
    strobe('0);
    repeat (40) tick();
    check("stall_level", 64'(evt_level), 64'd16);
    strobe(48'd1 << 20);
    repeat (5) tick();
    check("revert_ovf", 64'(ovf), 64'd1);
    model_events(model_word, 48'd1 << 20);
    collect(120, 1'b0);
    compare_stream("revert");
    model_word = 48'd1 << 20;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 64'(ovf), 64'd0);
    tick();

    // Clear request colliding with a new set condition: set wins.
    strobe(ALL_ONES);
    repeat (30) tick();
    gp_value = ALL_ONES;
    gp_stb   = 1'b1;
    ovf_clr  = 1'b1;
    tick();
    gp_stb   = 1'b0;
    ovf_clr  = 1'b0;
    @(negedge clk);
    check("ovf_set_wins", 64'(ovf), 64'd1);
    tick();
    model_events(model_word, ALL_ONES);
    collect(120, 1'b0);
    compare_stream("setwins");
    model_word = ALL_ONES;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Asynchronous reset in the middle of a scan.
    strobe('0);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (evt_level == 5'd7) begin
        found = 1;
        break;
      end
    end
    check("midrst_reached7", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(evt_valid), 64'd0);
    check("midrst_level", 64'(evt_level), 64'd0);
    check("midrst_data",  64'(evt_data),  64'd0);
    check("midrst_ovf",   64'(ovf),       64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    strobe(48'h0000_0000_0123);
    repeat (20) tick();
    check("postrst_level", 64'(evt_level), 64'd0);
    check("postrst_valid", 64'(evt_valid), 64'd0);
    model_word = 48'h0000_0000_0123;

    // Randomized scans with a randomly stalling consumer.
    for (int r = 0; r < 10; r++) begin
      nw = {16'($urandom), 32'($urandom)};
      strobe(nw);
      model_events(model_word, nw);
      collect(300, 1'b1);
      compare_stream($sformatf("rand%0d", r));
      check($sformatf("rand%0d_ovf", r), 64'(ovf), 64'd0);
      model_word = nw;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
